// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Purpose  : Synchronous up/down modulo counter with load, wrap/saturate mode,
//            terminal-count, wrap-pulse and saturation-flag outputs.
// Revision : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 16,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] load_val;
    logic             sat_q;

    assign at_max   = (q == MAX_VAL);
    assign at_min   = (q == ZERO);
    // Out-of-range load values clamp to the top of the count range.
    assign load_val = (d > MAX_VAL) ? MAX_VAL : d;

    assign tc  = (up_dn & at_max) | (~up_dn & at_min);
    assign sat = SATURATE ? sat_q : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= RST_VAL;
            wrap  <= 1'b0;
            sat_q <= 1'b0;
        end else if (load) begin
            q     <= load_val;
            wrap  <= 1'b0;
            sat_q <= 1'b0;
        end else if (en) begin
            wrap <= 1'b0;
            if (up_dn) begin
                if (!at_max) begin
                    q     <= q + ONE;
                    sat_q <= 1'b0;
                end else if (SATURATE) begin
                    sat_q <= 1'b1;
                end else begin
                    q     <= ZERO;
                    wrap  <= 1'b1;
                    sat_q <= 1'b0;
                end
            end else begin
                if (!at_min) begin
                    q     <= q - ONE;
                    sat_q <= 1'b0;
                end else if (SATURATE) begin
                    sat_q <= 1'b1;
                end else begin
                    q     <= MAX_VAL;
                    wrap  <= 1'b1;
                    sat_q <= 1'b0;
                end
            end
        end else begin
            // Idle edge: hold count and saturation level, drop the wrap pulse.
            wrap <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_updown_counter
// Purpose  : Directed self-checking bench for param_updown_counter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_param_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // A: wrap mode, MODULUS 10
    logic       a_reset, a_en, a_up, a_load;
    logic [3:0] a_d, a_q;
    logic       a_tc, a_wrap, a_sat;
    // B: saturate mode, MODULUS 16
    logic       b_reset, b_en, b_up, b_load;
    logic [3:0] b_d, b_q;
    logic       b_tc, b_wrap, b_sat;
    // C: power-of-two modulus, non-zero reset value
    logic       c_reset, c_en, c_up, c_load;
    logic [2:0] c_d, c_q;
    logic       c_tc, c_wrap, c_sat;

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(0)) u_a (
        .clk(clk), .reset(a_reset), .en(a_en), .up_dn(a_up), .load(a_load),
        .d(a_d), .q(a_q), .tc(a_tc), .wrap(a_wrap), .sat(a_sat));

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1), .RESET_VAL(0)) u_b (
        .clk(clk), .reset(b_reset), .en(b_en), .up_dn(b_up), .load(b_load),
        .d(b_d), .q(b_q), .tc(b_tc), .wrap(b_wrap), .sat(b_sat));

    param_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0), .RESET_VAL(5)) u_c (
        .clk(clk), .reset(c_reset), .en(c_en), .up_dn(c_up), .load(c_load),
        .d(c_d), .q(c_q), .tc(c_tc), .wrap(c_wrap), .sat(c_sat));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        a_reset = 1; a_en = 0; a_up = 1; a_load = 0; a_d = '0;
        b_reset = 1; b_en = 0; b_up = 1; b_load = 0; b_d = '0;
        c_reset = 1; c_en = 0; c_up = 1; c_load = 0; c_d = '0;
        tick(); tick();
        check("a_rst_q", a_q, 0);
        check("a_rst_wrap", a_wrap, 0);
        check("a_rst_sat", a_sat, 0);
        check("a_rst_tc", a_tc, 0);
        check("b_rst_sat", b_sat, 0);
        check("c_rst_q", c_q, 5);
        a_reset = 0; b_reset = 0; c_reset = 0;

        // Up count through the wrap point
        a_en = 1; a_up = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e = k % 10;
            check($sformatf("up_q%0d", k), a_q, e);
            check($sformatf("up_wrap%0d", k), a_wrap, (e == 0));
            check($sformatf("up_tc%0d", k), a_tc, (e == 9));
        end

        // Load 2, count down through underflow
        a_en = 0; a_load = 1; a_d = 4'd2;
        tick();
        check("dn_load_q", a_q, 2);
        a_load = 0; a_en = 1; a_up = 0;
        check("dn_tc_at2", a_tc, 0);
        begin
            int exp_dn [4] = '{1, 0, 9, 8};
            for (int k = 0; k < 4; k++) begin
                tick();
                check($sformatf("dn_q%0d", k), a_q, exp_dn[k]);
                check($sformatf("dn_wrap%0d", k), a_wrap, (exp_dn[k] == 9));
                check($sformatf("dn_tc%0d", k), a_tc, (exp_dn[k] == 0));
            end
        end

        // Load wins over enable; out-of-range load clamps
        a_load = 1; a_en = 1; a_up = 1; a_d = 4'd3;
        tick();
        check("ld_pri_q", a_q, 3);
        check("ld_pri_wrap", a_wrap, 0);
        a_d = 4'd12;
        tick();
        check("ld_clamp_q", a_q, 9);
        a_d = 4'd15;
        tick();
        check("ld_clamp15_q", a_q, 9);

        // Mid-count reset beats load and enable
        a_d = 4'd4; tick();
        a_load = 0; tick();
        check("mr_q5", a_q, 5);
        a_reset = 1; a_load = 1; a_en = 1; a_d = 4'd7;
        tick();
        check("mr_q", a_q, 0);
        check("mr_wrap", a_wrap, 0);
        check("mr_sat", a_sat, 0);
        a_reset = 0; a_load = 0;
        tick();
        check("mr_resume_q", a_q, 1);

        // Enable gating and direction flip: 4,5,5,6,6,5
        a_load = 1; a_en = 0; a_d = 4'd4; tick();
        a_load = 0;
        a_en = 1; tick(); check("eg_q1", a_q, 5);
        a_en = 0; tick(); check("eg_q2", a_q, 5);
        a_en = 1; tick(); check("eg_q3", a_q, 6);
        a_en = 0; a_up = 0; tick(); check("eg_q4", a_q, 6);
        a_en = 1; tick(); check("eg_q5", a_q, 5);
        a_en = 0;

        // tc follows up_dn with no clock edge
        a_load = 1; a_d = 4'd9; a_up = 1; tick(); a_load = 0;
        check("tc_up9", a_tc, 1);
        a_up = 0; #1;
        check("tc_dn9", a_tc, 0);
        a_load = 1; a_d = 4'd0; tick(); a_load = 0;
        check("tc_dn0", a_tc, 1);
        a_up = 1; #1;
        check("tc_up0", a_tc, 0);
        // Wrap pulse lasts one cycle only, even while idle
        a_load = 1; a_d = 4'd9; tick(); a_load = 0;
        a_en = 1; tick(); a_en = 0;
        check("wp_q", a_q, 0);
        check("wp_on", a_wrap, 1);
        tick();
        check("wp_off", a_wrap, 0);
        check("wp_hold_q", a_q, 0);

        // Saturate mode
        b_load = 1; b_d = 4'd14; tick(); b_load = 0;
        b_en = 1; b_up = 1;
        tick(); check("sat_q1", b_q, 15); check("sat_s1", b_sat, 0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("sat_q%0d", k), b_q, 15);
            check($sformatf("sat_s%0d", k), b_sat, 1);
            check($sformatf("sat_w%0d", k), b_wrap, 0);
        end
        b_en = 0; tick();
        check("sat_hold", b_sat, 1);
        b_en = 1; b_up = 0; tick();
        check("sat_dn_q", b_q, 14);
        check("sat_dn_s", b_sat, 0);
        b_en = 0; b_load = 1; b_d = 4'd0; tick(); b_load = 0;
        b_en = 1; tick();
        check("sat_lo_q", b_q, 0);
        check("sat_lo_s", b_sat, 1);
        b_en = 0; b_load = 1; b_d = 4'd15; tick(); b_load = 0;
        check("sat_ld_q", b_q, 15);
        check("sat_ld_s", b_sat, 0);

        // Full-range modulus: explicit wrap at 7 and underflow at 0
        c_load = 1; c_d = 3'd7; tick(); c_load = 0;
        c_en = 1; c_up = 1; tick();
        check("c_up_q", c_q, 0);
        check("c_up_wrap", c_wrap, 1);
        c_up = 0; tick();
        check("c_dn_q", c_q, 7);
        check("c_dn_wrap", c_wrap, 1);
        tick();
        check("c_dn2_q", c_q, 6);
        check("c_dn2_wrap", c_wrap, 0);
        check("c_sat", c_sat, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
